// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous initiator for the tinycpu asynchronous SRAM bus.
// Each accepted request runs SETUP -> PULSE -> HOLD -> RECOVER.
// Every SRAM-side output, including the dq drive enable, comes straight from a flop.
// Optional feature macro: SRAM_CTRL_VERIFY_EN. When defined, each write is followed by an
// internal read-back of the same address, and verify_err flags a data mismatch.
module sram_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       verify_err,
  output logic [7:0] sram_addr,
  output logic       sram_cen,
  output logic       sram_wen,
  output logic       sram_oen,
  inout  wire  [7:0] sram_dq
);

  // Counter load value for a phase of cyc cycles: 0 is treated as 1, and anything
  // above 15 is clamped to 15.
  function automatic logic [3:0] ld_val(input int unsigned cyc);
    if (cyc <= 1) begin
      return 4'd0;
    end else if (cyc >= 15) begin
      return 4'd14;
    end else begin
      return 4'(cyc - 1);
    end
  endfunction

  localparam logic [3:0] SetupLd = ld_val(SETUP_CYC);
  localparam logic [3:0] PulseLd = ld_val(PULSE_CYC);
  localparam logic [3:0] HoldLd  = ld_val(HOLD_CYC);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StRecover
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        cen_q, cen_d;
  logic        wen_q, wen_d;
  logic        oen_q, oen_d;
  logic        dq_oe_q, dq_oe_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        busy_d;

`ifdef SRAM_CTRL_VERIFY_EN
  // rb_q marks the internal read-back pass that follows a write.
  logic        rb_q, rb_d;
  logic        verify_err_q, verify_err_d;
`endif

  // Next-state logic, request capture and phase timing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_CTRL_VERIFY_EN
    rb_d    = rb_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = SetupLd;
          state_d = StSetup;
`ifdef SRAM_CTRL_VERIFY_EN
          rb_d    = 1'b0;
`endif
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = PulseLd;
          state_d = StPulse;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StPulse: begin
        if (cnt_q == 4'd0) begin
          // Sample the bus on the edge that ends the strobe, while oen is still low.
          if (!we_q) begin
            rdata_d = sram_dq;
          end
          cnt_d   = HoldLd;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRecover: begin
        state_d = StIdle;
`ifdef SRAM_CTRL_VERIFY_EN
        // A finished write turns into a read of the same address.
        if (we_q) begin
          we_d    = 1'b0;
          rb_d    = 1'b1;
          cnt_d   = SetupLd;
          state_d = StSetup;
        end
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered strobe values are decoded from the next state, so pins change only on edges.
  always_comb begin
    busy_d  = (state_d == StSetup) || (state_d == StPulse) || (state_d == StHold);
    cen_d   = !busy_d;
    wen_d   = !((state_d == StPulse) && we_d);
    oen_d   = !((state_d == StPulse) && !we_d);
    dq_oe_d = busy_d && we_d;
`ifdef SRAM_CTRL_VERIFY_EN
    // The write's own RECOVER stays silent; the read-back RECOVER reports.
    rsp_valid_d  = (state_d == StRecover) && !we_d;
    verify_err_d = (state_d == StRecover) && rb_q && (rdata_q != wdata_q);
`else
    rsp_valid_d  = (state_d == StRecover);
`endif
  end

  // State, request and SRAM pin registers; reset parks the bus idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      cen_q       <= 1'b1;
      wen_q       <= 1'b1;
      oen_q       <= 1'b1;
      dq_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      oen_q       <= oen_d;
      dq_oe_q     <= dq_oe_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef SRAM_CTRL_VERIFY_EN
  // Read-back tracking and the mismatch flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_q         <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      rb_q         <= rb_d;
      verify_err_q <= verify_err_d;
    end
  end

  assign verify_err = verify_err_q;
`else
  assign verify_err = 1'b0;
`endif

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign sram_addr = addr_q;
  assign sram_cen  = cen_q;
  assign sram_wen  = wen_q;
  assign sram_oen  = oen_q;
  // wdata_q is only loaded in IDLE, so the driven value is stable for the whole cycle.
  assign sram_dq   = dq_oe_q ? wdata_q : 8'bz;

  // Bus protocol invariants.
  a_strobe_excl : assert property (@(posedge clk) disable iff (rst) !(!sram_wen && !sram_oen));
  a_wen_in_cen  : assert property (@(posedge clk) disable iff (rst) !sram_wen |-> !sram_cen);
  a_oen_in_cen  : assert property (@(posedge clk) disable iff (rst) !sram_oen |-> !sram_cen);

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed, table-driven bench for sram_ctrl with a behavioural SRAM model.
// Undriven dq bits are pulled up, so a released bus reads as 0xFF.
module tb_sram_ctrl;

  localparam int RdLen = 5;
`ifdef SRAM_CTRL_VERIFY_EN
  localparam int WrLen    = 10;
  localparam bit VerifyOn = 1'b1;
`else
  localparam int WrLen    = 5;
  localparam bit VerifyOn = 1'b0;
`endif

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       flip;       // model forces dq[0]=1 on reads
    logic [7:0] exp_rdata;  // data the read (or read-back) must return
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       req_ready, rsp_valid, verify_err;
  logic [7:0] rsp_rdata, sram_addr;
  logic       sram_cen, sram_wen, sram_oen;
  wire  [7:0] sram_dq;

  logic       mem_init;
  logic       flip;
  logic [7:0] mem [256];
  logic [7:0] last_rdata;
  int         n_checks = 0;
  int         n_fail   = 0;
  vec_t       vecs[$];

  wire [21:0] obs_vec = {req_ready, sram_cen, sram_wen, sram_oen, rsp_valid, verify_err,
                         sram_addr, sram_dq};

  always #5 clk = ~clk;

  sram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .verify_err(verify_err),
    .sram_addr (sram_addr),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_oen  (sram_oen),
    .sram_dq   (sram_dq)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (sram_dq[gi]);
  end

  // SRAM model: preloaded with addr ^ 0x5A, written while cen and wen are both low.
  always_ff @(posedge clk or posedge mem_init) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (!sram_cen && !sram_wen) begin
      mem[sram_addr] <= sram_dq;
    end
  end

  assign sram_dq = (!sram_cen && !sram_oen) ? (mem[sram_addr] | {7'd0, flip}) : 8'bz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Expected pins in cycle c after acceptance, for an operation that takes len cycles.
  // Each SRAM pass is 5 cycles: SETUP(1) PULSE(2,3) HOLD(4) RECOVER(5).
  function automatic logic [21:0] exp_cycle(input logic we, input logic [7:0] addr,
                                            input logic [7:0] wdata, input logic [7:0] rdval,
                                            input int c, input int len, input logic err);
    int         pc;
    logic       ph_we, act, rdy, cen, wen, oen, rv, ve;
    logic [7:0] dq;
    pc    = (c - 1) % 5 + 1;
    act   = (c <= len);
    ph_we = we && (c <= 5);
    rdy   = (c > len);
    cen   = !(act && pc <= 4);
    wen   = !(act && ph_we && (pc == 2 || pc == 3));
    oen   = !(act && !ph_we && (pc == 2 || pc == 3));
    rv    = (c == len);
    ve    = (c == len) && err;
    dq    = 8'hFF;
    if (act && ph_we && pc <= 4) dq = wdata;
    else if (!oen) dq = rdval;
    return {rdy, cen, wen, oen, rv, ve, addr, dq};
  endfunction

  task automatic do_txn(input vec_t v, input string tag);
    int         len;
    logic [7:0] rd_exp;
    len = v.we ? WrLen : RdLen;
    @(negedge clk);
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    flip      = v.flip;
    @(posedge clk);
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Junk on the request fields must be ignored while busy.
        req_valid = 1'b0;
        req_we    = ~v.we;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
      end
      check($sformatf("%s/cyc%0d", tag, c), 32'(obs_vec),
            32'(exp_cycle(v.we, v.addr, v.wdata, v.exp_rdata, c, len, v.exp_err)));
      if (c == len) begin
        rd_exp = (v.we && !VerifyOn) ? last_rdata : v.exp_rdata;
        check({tag, "/rdata"}, 32'(rsp_rdata), 32'(rd_exp));
        last_rdata = rd_exp;
      end
    end
    if (v.we) check({tag, "/mem"}, 32'(mem[v.addr]), 32'(v.wdata));
    flip = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int         run, gap, rdy_low;
    logic       had_low;
    logic [21:0] exp;

    rst        = 1'b1;
    mem_init   = 1'b1;
    flip       = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 8'h00;
    last_rdata = 8'h00;

    // Reset values, sampled while reset is still asserted.
    repeat (3) @(posedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    check("rst/cen",    32'(sram_cen),   32'd1);
    check("rst/wen",    32'(sram_wen),   32'd1);
    check("rst/oen",    32'(sram_oen),   32'd1);
    check("rst/dq",     32'(sram_dq),    32'hFF);
    check("rst/ready",  32'(req_ready),  32'd1);
    check("rst/rvalid", 32'(rsp_valid),  32'd0);
    check("rst/rdata",  32'(rsp_rdata),  32'h00);
    check("rst/verr",   32'(verify_err), 32'd0);
    check("rst/addr",   32'(sram_addr),  32'h00);
    rst = 1'b0;

    // Single transactions.
    vecs.push_back('{1'b1, 8'h7F, 8'h46, 1'b0, 8'h46, 1'b0});
    vecs.push_back('{1'b0, 8'h7F, 8'h00, 1'b0, 8'h46, 1'b0});
    vecs.push_back('{1'b0, 8'h05, 8'h00, 1'b0, 8'h5F, 1'b0});
    vecs.push_back('{1'b1, 8'h80, 8'hC3, 1'b0, 8'hC3, 1'b0});
    vecs.push_back('{1'b0, 8'h80, 8'h00, 1'b0, 8'hC3, 1'b0});
    vecs.push_back('{1'b0, 8'hFF, 8'h00, 1'b0, 8'hA5, 1'b0});
`ifdef SRAM_CTRL_VERIFY_EN
    vecs.push_back('{1'b1, 8'h20, 8'h3C, 1'b0, 8'h3C, 1'b0});
    vecs.push_back('{1'b1, 8'h20, 8'h3C, 1'b1, 8'h3D, 1'b1});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: req_valid held, write 0x10 <- 0xA5 then read 0x10.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h10;
    req_wdata = 8'hA5;
    @(posedge clk);
    run     = 0;
    gap     = 0;
    rdy_low = 0;
    had_low = 1'b0;
    for (int c = 1; c <= WrLen + 1 + RdLen + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_we    = 1'b0;
        req_wdata = 8'h00;
      end
      if (c <= WrLen + 1) exp = exp_cycle(1'b1, 8'h10, 8'hA5, 8'hA5, c, WrLen, 1'b0);
      else exp = exp_cycle(1'b0, 8'h10, 8'h00, 8'hA5, c - WrLen - 1, RdLen, 1'b0);
      check($sformatf("b2b/cyc%0d", c), 32'(obs_vec), 32'(exp));
      if (!req_ready) rdy_low++;
      if (sram_cen) begin
        run++;
      end else begin
        if (had_low && run > 0) gap = run;
        had_low = 1'b1;
        run     = 0;
      end
      if (c == WrLen + 1 + RdLen) begin
        check("b2b/rdata", 32'(rsp_rdata), 32'hA5);
        req_valid = 1'b0;
      end
    end
    last_rdata = 8'hA5;
    check("b2b/ready_low", 32'(rdy_low), 32'(WrLen + RdLen));
    check("b2b/cen_gap",   32'(gap),     32'd2);

    // Reset in the middle of a write strobe.
    @(negedge clk);
    check("midrst/ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h33;
    req_wdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst/pulse", 32'({sram_cen, sram_wen, sram_dq}), 32'({2'b00, 8'h77}));
    #1 rst = 1'b1;
    #1 check("midrst/async", 32'({sram_cen, sram_wen, sram_oen, rsp_valid, sram_dq}),
             32'({4'b1110, 8'hFF}));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("midrst/idle%0d", c), 32'({rsp_valid, req_ready, sram_cen}), 32'b011);
    end
    check("midrst/rdata", 32'(rsp_rdata), 32'h00);
    last_rdata = 8'h00;
    do_txn('{1'b0, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0}, "midrst/rd00");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
